// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with write-through forwarding and a
// per-register pending scoreboard for decode-stage RAW/WAW hazard detection.
// Latency: reads are combinational (READ_REG=0) or valid one cycle after the
// address (READ_REG=1). Scoreboard flags are combinational. pend_cnt is registered.
// Ports:
//   clk, rst                    rising-edge clock, async active-high reset
//   wr_en/wr_addr/wr_data       writeback port (address 0 is ignored)
//   rd_addr_x/rd_data_x         two read ports (address 0 always reads 0)
//   iss_en/iss_dest             issue side; marks iss_dest as awaiting writeback
//   rd_pend_x                   register at rd_addr_x is still awaiting writeback
//   hazard                      any read-side pending flag, or issue to a pending dest
//   pend_cnt                    number of registers currently pending
module reg_file_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int READ_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0] rd_data_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dest,
  output logic              rd_pend_1,
  output logic              rd_pend_2,
  output logic              hazard,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [ADDR_W:0]   pend_cnt_q;

  // ---------------------------------------------------------------------------
  // Storage. Each entry resets to its own index (truncated to DATA_W), so no
  // entry is ever unknown. Entry 0 is never written and resets to 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(i);
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding hits: a write to the same non-zero register in this cycle.
  // ---------------------------------------------------------------------------
  logic fwd_1;
  logic fwd_2;
  logic fwd_dest;

  assign fwd_1    = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_1);
  assign fwd_2    = (BYPASS != 0) && wr_en && (wr_addr == rd_addr_2);
  assign fwd_dest = (BYPASS != 0) && wr_en && (wr_addr == iss_dest);

  // Combinational read value, shared by both read modes so registered reads
  // capture exactly what a combinational read would have shown.
  logic [DATA_W-1:0] rd_comb_1;
  logic [DATA_W-1:0] rd_comb_2;

  always_comb begin
    rd_comb_1 = mem[rd_addr_1];
    if (rd_addr_1 == '0) begin
      rd_comb_1 = '0;
    end else if (fwd_1) begin
      rd_comb_1 = wr_data;
    end
  end

  always_comb begin
    rd_comb_2 = mem[rd_addr_2];
    if (rd_addr_2 == '0) begin
      rd_comb_2 = '0;
    end else if (fwd_2) begin
      rd_comb_2 = wr_data;
    end
  end

  generate
    if (READ_REG != 0) begin : g_rd_reg
      logic [DATA_W-1:0] rd_q_1;
      logic [DATA_W-1:0] rd_q_2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_q_1 <= '0;
          rd_q_2 <= '0;
        end else begin
          rd_q_1 <= rd_comb_1;
          rd_q_2 <= rd_comb_2;
        end
      end

      assign rd_data_1 = rd_q_1;
      assign rd_data_2 = rd_q_2;
    end else begin : g_rd_comb
      assign rd_data_1 = rd_comb_1;
      assign rd_data_2 = rd_comb_2;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scoreboard. Register 0 is never marked, so pending[0] stays 0 and the
  // address-0 masking on the read flags is only a safeguard.
  // ---------------------------------------------------------------------------
  logic set_en;
  logic clr_en;
  logic cnt_inc;
  logic cnt_dec;
  logic dest_pend;

  assign set_en = iss_en && (iss_dest != '0);
  assign clr_en = wr_en;

  // Count only real transitions: setting an already-pending bit adds nothing,
  // and a clear that is overridden by a same-edge set subtracts nothing.
  assign cnt_inc = set_en && !pending[iss_dest];
  assign cnt_dec = clr_en && pending[wr_addr] && !(set_en && (iss_dest == wr_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (clr_en) begin
        pending[wr_addr] <= 1'b0;
      end
      // Issued after the clear so a same-register collision leaves the bit set.
      if (set_en) begin
        pending[iss_dest] <= 1'b1;
      end
      case ({cnt_inc, cnt_dec})
        2'b10:   pend_cnt_q <= pend_cnt_q + CNT_ONE;
        2'b01:   pend_cnt_q <= pend_cnt_q - CNT_ONE;
        default: pend_cnt_q <= pend_cnt_q;
      endcase
    end
  end

  // A register being written back this cycle is no longer a hazard when the
  // write data is forwarded.
  assign rd_pend_1 = (rd_addr_1 != '0) && pending[rd_addr_1] && !fwd_1;
  assign rd_pend_2 = (rd_addr_2 != '0) && pending[rd_addr_2] && !fwd_2;
  assign dest_pend = pending[iss_dest] && !fwd_dest;
  assign hazard    = rd_pend_1 || rd_pend_2 || (iss_en && dest_pend);
  assign pend_cnt  = pend_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: three reg_file_sb configurations driven from one stimulus
// stream (narrower instances use the low address/data bits), each checked every
// cycle against a behavioural model, plus directed literal expectations.
module tb_reg_file_sb;

  localparam int NI = 3;
  localparam int AW   [NI] = '{4, 4, 5};
  localparam int DW   [NI] = '{8, 8, 16};
  localparam int RREG [NI] = '{0, 0, 1};
  localparam int BYP  [NI] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  rd_addr_1;
  logic [4:0]  rd_addr_2;
  logic        iss_en;
  logic [4:0]  iss_dest;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // DUT outputs gathered per instance, zero-extended to a common width.
  logic [15:0] o_rd1 [NI];
  logic [15:0] o_rd2 [NI];
  logic        o_p1  [NI];
  logic        o_p2  [NI];
  logic        o_hz  [NI];
  logic [5:0]  o_cnt [NI];

  logic [7:0]  a_rd1, a_rd2, b_rd1, b_rd2;
  logic [15:0] c_rd1, c_rd2;
  logic        a_p1, a_p2, a_hz, b_p1, b_p2, b_hz, c_p1, c_p2, c_hz;
  logic [4:0]  a_cnt, b_cnt;
  logic [5:0]  c_cnt;

  reg_file_sb #(.DATA_W(8), .ADDR_W(4), .READ_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data[7:0]),
    .rd_addr_1(rd_addr_1[3:0]), .rd_data_1(a_rd1), .rd_addr_2(rd_addr_2[3:0]), .rd_data_2(a_rd2),
    .iss_en(iss_en), .iss_dest(iss_dest[3:0]), .rd_pend_1(a_p1), .rd_pend_2(a_p2),
    .hazard(a_hz), .pend_cnt(a_cnt));

  reg_file_sb #(.DATA_W(8), .ADDR_W(4), .READ_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data[7:0]),
    .rd_addr_1(rd_addr_1[3:0]), .rd_data_1(b_rd1), .rd_addr_2(rd_addr_2[3:0]), .rd_data_2(b_rd2),
    .iss_en(iss_en), .iss_dest(iss_dest[3:0]), .rd_pend_1(b_p1), .rd_pend_2(b_p2),
    .hazard(b_hz), .pend_cnt(b_cnt));

  reg_file_sb #(.DATA_W(16), .ADDR_W(5), .READ_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_1(rd_addr_1), .rd_data_1(c_rd1), .rd_addr_2(rd_addr_2), .rd_data_2(c_rd2),
    .iss_en(iss_en), .iss_dest(iss_dest), .rd_pend_1(c_p1), .rd_pend_2(c_p2),
    .hazard(c_hz), .pend_cnt(c_cnt));

  assign o_rd1[0] = {8'h00, a_rd1};
  assign o_rd2[0] = {8'h00, a_rd2};
  assign o_rd1[1] = {8'h00, b_rd1};
  assign o_rd2[1] = {8'h00, b_rd2};
  assign o_rd1[2] = c_rd1;
  assign o_rd2[2] = c_rd2;
  assign o_p1[0]  = a_p1;
  assign o_p1[1]  = b_p1;
  assign o_p1[2]  = c_p1;
  assign o_p2[0]  = a_p2;
  assign o_p2[1]  = b_p2;
  assign o_p2[2]  = c_p2;
  assign o_hz[0]  = a_hz;
  assign o_hz[1]  = b_hz;
  assign o_hz[2]  = c_hz;
  assign o_cnt[0] = {1'b0, a_cnt};
  assign o_cnt[1] = {1'b0, b_cnt};
  assign o_cnt[2] = c_cnt;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst %0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a plain array of register values, a set of pending
  // register numbers (one flag per register) and the last captured read value.
  // ---------------------------------------------------------------------------
  int m_mem  [NI][32];
  int m_pend [NI][32];
  int m_rr1  [NI];
  int m_rr2  [NI];

  function automatic void model_reset(input int k);
    for (int i = 0; i < 32; i++) begin
      m_mem[k][i]  = i % (1 << DW[k]);
      m_pend[k][i] = 0;
    end
    m_rr1[k] = 0;
    m_rr2[k] = 0;
  endfunction

  // Value a read of register a sees during the current cycle.
  function automatic int cread(input int k, input int a, input int wa, input int wd);
    if (a == 0) return 0;
    if (BYP[k] != 0 && wr_en && wa == a) return wd;
    return m_mem[k][a];
  endfunction

  function automatic int cpend(input int k, input int a, input int wa);
    if (a == 0) return 0;
    if (BYP[k] != 0 && wr_en && wa == a) return 0;
    return m_pend[k][a];
  endfunction

  always @(negedge clk) begin
    int am, dm, wa, wd, a1, a2, id, c1, c2, p1, p2, dp, cnt;
    for (int k = 0; k < NI; k++) begin
      am = (1 << AW[k]) - 1;
      dm = (1 << DW[k]) - 1;
      wa = int'(wr_addr) & am;
      wd = int'(wr_data) & dm;
      a1 = int'(rd_addr_1) & am;
      a2 = int'(rd_addr_2) & am;
      id = int'(iss_dest) & am;
      if (rst) model_reset(k);
      c1 = cread(k, a1, wa, wd);
      c2 = cread(k, a2, wa, wd);
      p1 = cpend(k, a1, wa);
      p2 = cpend(k, a2, wa);
      dp = cpend(k, id, wa);
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += m_pend[k][i];
      chk("rd_data_1", k, o_rd1[k], (RREG[k] != 0) ? m_rr1[k] : c1);
      chk("rd_data_2", k, o_rd2[k], (RREG[k] != 0) ? m_rr2[k] : c2);
      chk("rd_pend_1", k, o_p1[k], p1);
      chk("rd_pend_2", k, o_p2[k], p2);
      chk("hazard", k, o_hz[k], (p1 != 0 || p2 != 0 || (iss_en && dp != 0)) ? 1 : 0);
      chk("pend_cnt", k, o_cnt[k], cnt);
      // State as it will be after the coming rising edge.
      if (rst) begin
        model_reset(k);
      end else begin
        m_rr1[k] = c1;
        m_rr2[k] = c2;
        if (wr_en && wa != 0) m_mem[k][wa] = wd;
        if (wr_en) m_pend[k][wa] = 0;
        if (iss_en && id != 0) m_pend[k][id] = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_1 = '0; rd_addr_2 = '0; iss_en = 1'b0; iss_dest = '0;
    step();
    step();

    // Reset contents: entry i holds i, register 0 reads 0.
    rst = 1'b0; rd_addr_1 = 5'd5; rd_addr_2 = 5'd0;
    #1;
    chk("lit_rst_rd5", 0, o_rd1[0], 5);
    chk("lit_rst_rd0", 0, o_rd2[0], 0);
    chk("lit_rst_cnt", 0, o_cnt[0], 0);
    rd_addr_1 = 5'd31;
    step(); #1;
    chk("lit_rst_rd31", 2, o_rd1[2], 31);
    chk("lit_rst_rd15", 0, o_rd1[0], 15);

    // Same-cycle write/read of register 7.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 16'h005A; rd_addr_1 = 5'd7;
    #1;
    chk("lit_fwd_byp1", 0, o_rd1[0], 16'h5A);
    chk("lit_fwd_byp0", 1, o_rd1[1], 16'h07);
    step();
    wr_en = 1'b0;
    #1;
    chk("lit_fwd_byp0_next", 1, o_rd1[1], 16'h5A);
    chk("lit_fwd_regrd", 2, o_rd1[2], 16'h5A);

    // Registered read latency.
    rd_addr_1 = 5'd9;
    step(); #1;
    chk("lit_regrd_9", 2, o_rd1[2], 9);

    // Writes to register 0 are dropped.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'h0011; rd_addr_1 = 5'd0;
    #1;
    chk("lit_r0_same", 0, o_rd1[0], 0);
    step();
    wr_en = 1'b0;
    #1;
    chk("lit_r0_next", 0, o_rd1[0], 0);
    chk("lit_r0_cnt", 0, o_cnt[0], 0);

    // Issue then writeback of register 4.
    iss_en = 1'b1; iss_dest = 5'd4; rd_addr_1 = 5'd4;
    step();
    iss_en = 1'b0;
    #1;
    chk("lit_iss4_pend", 0, o_p1[0], 1);
    chk("lit_iss4_haz", 0, o_hz[0], 1);
    chk("lit_iss4_cnt", 0, o_cnt[0], 1);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 16'h0044;
    #1;
    chk("lit_wb4_pend_byp1", 0, o_p1[0], 0);
    chk("lit_wb4_pend_byp0", 1, o_p1[1], 1);
    step();
    wr_en = 1'b0;
    #1;
    chk("lit_wb4_cnt", 0, o_cnt[0], 0);

    // Same-edge issue and writeback of pending register 6, then WAW issue.
    iss_en = 1'b1; iss_dest = 5'd6; rd_addr_1 = 5'd6;
    step();
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 16'h0066;
    #1;
    chk("lit_coll_cnt_before", 0, o_cnt[0], 1);
    step();
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    chk("lit_coll_cnt_after", 0, o_cnt[0], 1);
    chk("lit_coll_pend", 0, o_p1[0], 1);
    iss_en = 1'b1; iss_dest = 5'd6; rd_addr_1 = 5'd0; rd_addr_2 = 5'd0;
    #1;
    chk("lit_waw_haz", 0, o_hz[0], 1);
    step();
    iss_en = 1'b0;
    #1;
    chk("lit_waw_cnt", 0, o_cnt[0], 1);
    wr_en = 1'b1; wr_addr = 5'd6;
    step();
    wr_en = 1'b0;

    // Fill the whole scoreboard, re-issue to a pending register, then drain.
    for (int i = 1; i < 16; i++) begin
      iss_en = 1'b1; iss_dest = 5'(i);
      step();
    end
    iss_dest = 5'd3;
    step();
    iss_en = 1'b0;
    #1;
    chk("lit_full_cnt", 0, o_cnt[0], 15);
    chk("lit_full_cnt", 2, o_cnt[2], 15);
    for (int i = 1; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 16'(i * 3);
      step();
    end
    wr_addr = 5'd5;
    step();
    wr_en = 1'b0;
    #1;
    chk("lit_drain_cnt", 0, o_cnt[0], 0);
    chk("lit_drain_cnt", 2, o_cnt[2], 0);

    // Reset asserted mid-operation while a write to register 3 is presented.
    iss_en = 1'b1; iss_dest = 5'd2;
    step();
    iss_en = 1'b0;
    #1;
    chk("lit_pre_rst_cnt", 0, o_cnt[0], 1);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h00AA;
    #1;
    chk("lit_async_rst_cnt", 0, o_cnt[0], 0);
    step();
    rst = 1'b0; wr_en = 1'b0; rd_addr_1 = 5'd3;
    #1;
    chk("lit_rst_r3", 0, o_rd1[0], 3);
    chk("lit_rst_r3_cnt", 0, o_cnt[0], 0);

    // Randomised traffic, including occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_addr   = 5'($urandom);
      wr_data   = 16'($urandom);
      rd_addr_1 = 5'($urandom);
      rd_addr_2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      iss_en    = ($urandom_range(0, 1) != 0);
      iss_dest  = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      step();
    end

    rst = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
